// File: rtl/fpu_add_seq_if.sv
// Request/response bundle for fpu_add_seq: operands and start in, registered result and status out.
interface fpu_add_seq_if;
    logic        start;
    logic        sub;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    logic        busy;
    logic        done;
    logic        overflow;
    logic        invalid;

    modport master (
        output start, sub, a, b,
        input  result, busy, done, overflow, invalid
    );

    modport slave (
        input  start, sub, a, b,
        output result, busy, done, overflow, invalid
    );
endinterface

// File: rtl/fpu_add_seq.sv
// Sequential IEEE-754 single-precision add/subtract (IDLE/ALIGN/ADD/NORM/ROUND/DONE).
// Define FPU_RNE_EN for round-to-nearest-even; the default build truncates with identical latency.
module fpu_add_seq #(
    parameter logic [31:0] NAN_PATTERN = 32'h7FC00000
) (
    input logic          clk,
    input logic          reset,
    fpu_add_seq_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_t;
    state_t r_state, w_next;

    logic        r_sa, r_sb;
    logic [7:0]  r_ea, r_eb;
    logic [22:0] r_fa, r_fb;
    logic [26:0] r_mx, r_my;
    logic        r_sx, r_sy;
    logic [27:0] r_sum;
    logic        r_sign;
    logic [9:0]  r_exp;
    logic [31:0] r_result;
    logic        r_ovf, r_inv;

    logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_special, w_spec_inv;
    logic [31:0] w_spec_result;
    logic [23:0] w_ma, w_mb, w_mbig, w_msml;
    logic        w_a_big;
    logic [7:0]  w_ebig, w_diff;
    logic [26:0] w_ext, w_mask, w_aligned;

    always_comb begin
        w_a_nan    = (r_ea == 8'hFF) && (r_fa != '0);
        w_b_nan    = (r_eb == 8'hFF) && (r_fb != '0);
        w_a_inf    = (r_ea == 8'hFF) && (r_fa == '0);
        w_b_inf    = (r_eb == 8'hFF) && (r_fb == '0);
        w_special  = (r_ea == 8'hFF) || (r_eb == 8'hFF);
        w_spec_inv = w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (r_sa != r_sb));
        if (w_spec_inv)
            w_spec_result = NAN_PATTERN;
        else if (w_a_inf)
            w_spec_result = {r_sa, 8'hFF, 23'd0};
        else
            w_spec_result = {r_sb, 8'hFF, 23'd0};

        // Zero-exponent operands (zeros and subnormals) contribute no magnitude.
        w_ma    = (r_ea == '0) ? '0 : {1'b1, r_fa};
        w_mb    = (r_eb == '0) ? '0 : {1'b1, r_fb};
        w_a_big = (r_ea >= r_eb);
        w_ebig  = w_a_big ? r_ea : r_eb;
        w_diff  = w_a_big ? (r_ea - r_eb) : (r_eb - r_ea);
        w_mbig  = w_a_big ? w_ma : w_mb;
        w_msml  = w_a_big ? w_mb : w_ma;
        w_ext   = {w_msml, 3'b000};
        w_mask  = '0;
        if (w_diff >= 8'd26) begin
            w_aligned = {26'd0, |w_msml};
        end else begin
            w_mask    = ~({27{1'b1}} << w_diff);
            w_aligned = (w_ext >> w_diff) | {26'd0, |(w_ext & w_mask)};
        end
    end

    logic [27:0] w_add_sum;
    logic        w_add_sign;

    always_comb begin
        if (r_sx == r_sy) begin
            w_add_sum  = {1'b0, r_mx} + {1'b0, r_my};
            w_add_sign = r_sx;
        end else if (r_mx >= r_my) begin
            w_add_sum  = {1'b0, r_mx - r_my};
            w_add_sign = r_sx;
        end else begin
            w_add_sum  = {1'b0, r_my - r_mx};
            w_add_sign = r_sy;
        end
        if (w_add_sum == '0)
            w_add_sign = 1'b0;
    end

    logic [27:0] w_norm_sum;
    logic [9:0]  w_norm_exp;
    logic        w_norm_last;

    // A left shift ends NORM when it lands the leading one on bit 26, so k equals the shift count.
    always_comb begin
        w_norm_sum  = r_sum;
        w_norm_exp  = r_exp;
        w_norm_last = 1'b1;
        if (r_sum[27]) begin
            w_norm_sum = {1'b0, r_sum[27:2], r_sum[1] | r_sum[0]};
            w_norm_exp = r_exp + 10'd1;
        end else if (!r_sum[26] && (r_sum != '0)) begin
            w_norm_sum  = {r_sum[26:0], 1'b0};
            w_norm_exp  = r_exp - 10'd1;
            w_norm_last = r_sum[25];
        end
    end

    logic        w_inc;
    logic [24:0] w_rsum;
    logic [9:0]  w_rexp;
    logic [22:0] w_rfrac;
    logic [31:0] w_round_result;
    logic        w_round_ovf;

    always_comb begin
`ifdef FPU_RNE_EN
        w_inc = r_sum[2] & (r_sum[1] | r_sum[0] | r_sum[3]);
`else
        w_inc = 1'b0;
`endif
        w_rsum      = {1'b0, r_sum[26:3]} + {24'd0, w_inc};
        w_rexp      = r_exp + {9'd0, w_rsum[24]};
        w_rfrac     = w_rsum[24] ? w_rsum[23:1] : w_rsum[22:0];
        w_round_ovf = 1'b0;
        if (r_sum == '0) begin
            w_round_result = '0;
        end else if (!w_rexp[9] && (w_rexp >= 10'd255)) begin
            w_round_result = {r_sign, 8'hFF, 23'd0};
            w_round_ovf    = 1'b1;
        end else if (w_rexp[9] || (w_rexp == '0)) begin
            w_round_result = {r_sign, 31'd0};
        end else begin
            w_round_result = {r_sign, w_rexp[7:0], w_rfrac};
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_next = ALIGN;
            ALIGN:   w_next = w_special ? DONE : ADD;
            ADD:     w_next = NORM;
            NORM:    if (w_norm_last) w_next = ROUND;
            ROUND:   w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_ea     <= '0;
            r_eb     <= '0;
            r_fa     <= '0;
            r_fb     <= '0;
            r_mx     <= '0;
            r_my     <= '0;
            r_sx     <= 1'b0;
            r_sy     <= 1'b0;
            r_sum    <= '0;
            r_sign   <= 1'b0;
            r_exp    <= '0;
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_inv    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (bus.start) begin
                    r_sa <= bus.a[31];
                    r_sb <= bus.b[31] ^ bus.sub;
                    r_ea <= bus.a[30:23];
                    r_eb <= bus.b[30:23];
                    r_fa <= bus.a[22:0];
                    r_fb <= bus.b[22:0];
                end
                ALIGN: begin
                    r_mx  <= {w_mbig, 3'b000};
                    r_my  <= w_aligned;
                    r_exp <= {2'b00, w_ebig};
                    r_sx  <= w_a_big ? r_sa : r_sb;
                    r_sy  <= w_a_big ? r_sb : r_sa;
                    if (w_special) begin
                        r_result <= w_spec_result;
                        r_inv    <= w_spec_inv;
                        r_ovf    <= 1'b0;
                    end
                end
                ADD: begin
                    r_sum  <= w_add_sum;
                    r_sign <= w_add_sign;
                end
                NORM: begin
                    r_sum <= w_norm_sum;
                    r_exp <= w_norm_exp;
                end
                ROUND: begin
                    r_result <= w_round_result;
                    r_ovf    <= w_round_ovf;
                    r_inv    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.result   = r_result;
    assign bus.overflow = r_ovf;
    assign bus.invalid  = r_inv;
    assign bus.busy     = (r_state != IDLE);
    assign bus.done     = (r_state == DONE);
endmodule

// File: tb/tb_fpu_add_seq.sv
// Directed bench for fpu_add_seq: exact-arithmetic reference model plus a per-cycle output checker.
module tb_fpu_add_seq;
`ifdef FPU_RNE_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] res;
        logic        ovf;
        logic        inv;
        logic [7:0]  lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic        pending;
    int          exp_acc, exp_due;
    exp_t        exp_r;
    logic [31:0] held_res;
    logic        held_ovf, held_inv;
    logic        c_busy, c_done;

    fpu_add_seq_if bus();

    fpu_add_seq #(.NAN_PATTERN(32'h7FC00000)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Exact sum on a 2^-149 grid, then rounding; lat is edges from the accepting edge to done.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
        exp_t        r;
        logic        sa, sb, ss, g, rest;
        int          ea, eb, ebig, p, e, k;
        logic [299:0] ma, mb, sm, tmp, mask, one;
        logic [24:0] m;
        r  = '0;
        sa = a[31];
        sb = b[31] ^ s;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0) ||
            (ea == 255 && eb == 255 && sa != sb)) begin
            r.res = 32'h7FC00000; r.inv = 1'b1; r.lat = 8'd1;
            return r;
        end
        if (ea == 255 || eb == 255) begin
            r.res = (ea == 255) ? {sa, 8'hFF, 23'd0} : {sb, 8'hFF, 23'd0};
            r.lat = 8'd1;
            return r;
        end
        one = 300'd1;
        ma  = (ea == 0) ? 300'd0 : ({276'd0, 1'b1, a[22:0]} << (ea - 1));
        mb  = (eb == 0) ? 300'd0 : ({276'd0, 1'b1, b[22:0]} << (eb - 1));
        if (sa == sb) begin sm = ma + mb; ss = sa; end
        else if (ma >= mb) begin sm = ma - mb; ss = sa; end
        else begin sm = mb - ma; ss = sb; end
        ebig = (ea > eb) ? ea : eb;
        if (sm == 0) begin
            r.lat = 8'd4;
            return r;
        end
        p = 0;
        for (int i = 0; i < 300; i++) if (sm[i]) p = i;
        k = ebig - (p - 22);
        if (k < 1) k = 1;
        r.lat = 8'(3 + k);
        if (p >= 24) begin
            tmp  = sm >> (p - 23);
            g    = sm[p - 24];
            mask = (one << (p - 24)) - one;
            rest = |(sm & mask);
        end else begin
            tmp  = sm << (23 - p);
            g    = 1'b0;
            rest = 1'b0;
        end
        m = {1'b0, tmp[23:0]};
        if (RNE && g && (rest || m[0])) m = m + 25'd1;
        e = p - 22;
        if (m[24]) begin m = m >> 1; e = e + 1; end
        if (e >= 255) begin
            r.res = {ss, 8'hFF, 23'd0}; r.ovf = 1'b1;
        end else if (e < 1) begin
            r.res = {ss, 31'd0};
        end else begin
            r.res = {ss, e[7:0], m[22:0]};
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, want);
        end
    endtask

    // Per-cycle checker: busy/done timing from the expected window, result/flags at done and while idle.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            chk("rst_busy", 32'(bus.busy), 32'd0);
            chk("rst_done", 32'(bus.done), 32'd0);
            chk("rst_result", bus.result, 32'd0);
            chk("rst_flags", {30'd0, bus.overflow, bus.invalid}, 32'd0);
        end else begin
            c_busy = pending && (cyc >= exp_acc) && (cyc <= exp_due);
            c_done = pending && (cyc == exp_due);
            chk("busy", 32'(bus.busy), 32'(c_busy));
            chk("done", 32'(bus.done), 32'(c_done));
            if (c_done) begin
                chk("result", bus.result, exp_r.res);
                chk("overflow", 32'(bus.overflow), 32'(exp_r.ovf));
                chk("invalid", 32'(bus.invalid), 32'(exp_r.inv));
                held_res = exp_r.res;
                held_ovf = exp_r.ovf;
                held_inv = exp_r.inv;
                pending  = 1'b0;
            end else if (!c_busy) begin
                chk("held_result", bus.result, held_res);
                chk("held_flags", {30'd0, bus.overflow, bus.invalid}, {30'd0, held_ovf, held_inv});
            end
        end
    end

    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
        exp_r     = model(a, b, s);
        bus.a     = a;
        bus.b     = b;
        bus.sub   = s;
        bus.start = 1'b1;
        exp_acc   = cyc + 1;
        exp_due   = cyc + 1 + int'(exp_r.lat);
        pending   = 1'b1;
    endtask

    task automatic finish_op(input string name, input logic [31:0] hand, input logic hovf,
                             input logic hinv, input logic hammer);
        int n;
        chk({name, "_model"}, exp_r.res, hand);
        @(negedge clk);
        bus.start = hammer;
        bus.a     = 32'h40490FDB;
        bus.b     = 32'h3F800000;
        n = 0;
        while (pending && n < 100) begin
            @(negedge clk);
            n++;
        end
        bus.start = 1'b0;
        if (pending) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no done within %0d cycles, expected at cycle %0d", name, n, exp_due);
            pending = 1'b0;
        end
        chk({name, "_res"}, bus.result, hand);
        chk({name, "_flags"}, {30'd0, bus.overflow, bus.invalid}, {30'd0, hovf, hinv});
    endtask

    task automatic run(input string name, input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [31:0] hand, input logic hovf, input logic hinv);
        @(negedge clk);
        launch(a, b, s);
        finish_op(name, hand, hovf, hinv, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.sub = 1'b0;
        bus.a = '0;
        bus.b = '0;
        pending = 1'b0;
        exp_acc = 0;
        exp_due = 0;
        exp_r = '0;
        held_res = '0;
        held_ovf = 1'b0;
        held_inv = 1'b0;
        #1;
        chk("init_result", bus.result, 32'd0);
        chk("init_busy", 32'(bus.busy), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        run("add_1_2",     32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0, 1'b0);
        run("cancel",      32'h3FC00000, 32'h3FC00000, 1'b1, 32'h00000000, 1'b0, 1'b0);
        run("ovf",         32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 1'b0);
        run("inf_m_inf",   32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 1'b0, 1'b1);
        run("tie_even",    32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 1'b0, 1'b0);
        run("big_tie",     32'h4B800000, 32'h3F800000, 1'b0, 32'h4B800000, 1'b0, 1'b0);
        run("nan_in",      32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 1'b0, 1'b1);
        run("ninf_plus",   32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 1'b0, 1'b0);
        run("fin_m_inf",   32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 1'b0, 1'b0);
        run("zero_plus",   32'h00000000, 32'hC0490FDB, 1'b0, 32'hC0490FDB, 1'b0, 1'b0);
        run("denorm_flush",32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 1'b0, 1'b0);
        run("signed_canc", 32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000, 1'b0, 1'b0);
        run("neg_sum",     32'hBFC00000, 32'h40100000, 1'b1, 32'hC0700000, 1'b0, 1'b0);
        run("larger_neg",  32'h3F800000, 32'h40A00000, 1'b1, 32'hC0800000, 1'b0, 1'b0);
        run("lshift24",    32'h3F800000, 32'h3F7FFFFF, 1'b1, 32'h33800000, 1'b0, 1'b0);
        run("underflow",   32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 1'b0, 1'b0);
`ifdef FPU_RNE_EN
        run("rnd_odd",     32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 1'b0, 1'b0);
        run("rnd_up",      32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 1'b0, 1'b0);
        run("rnd_ovf",     32'h7F7FFFFF, 32'h73000000, 1'b0, 32'h7F800000, 1'b1, 1'b0);
`else
        run("rnd_odd",     32'h3F800001, 32'h33800000, 1'b0, 32'h3F800001, 1'b0, 1'b0);
        run("rnd_up",      32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800000, 1'b0, 1'b0);
        run("rnd_ovf",     32'h7F7FFFFF, 32'h73000000, 1'b0, 32'h7F7FFFFF, 1'b0, 1'b0);
`endif

        // start held high through the whole operation must not queue a second one
        @(negedge clk);
        launch(32'h3F800000, 32'h40000000, 1'b0);
        finish_op("hammer", 32'h40400000, 1'b0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);

        // reset two cycles into an operation, then restart right after release
        @(negedge clk);
        launch(32'h3F800000, 32'h40000000, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b1;
        pending = 1'b0;
        held_res = '0;
        held_ovf = 1'b0;
        held_inv = 1'b0;
        #1;
        chk("async_busy", 32'(bus.busy), 32'd0);
        chk("async_done", 32'(bus.done), 32'd0);
        chk("async_result", bus.result, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        launch(32'h40400000, 32'h3F800000, 1'b1);
        finish_op("after_rst", 32'h40000000, 1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end
endmodule
